dbus_demux: RTL and testbench
=============================

# dbus_demux

Single-initiator, two-target data-bus router between the MIPS core's load/store port and its memory system. It decodes each request address and steers the request to data memory (target 0) or the MMIO window (target 1). It holds one transaction outstanding and returns the selected target's response to the core, or an error response when the target does not answer within a bounded time.

## Interface
- ADDR_W, 32, request address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MMIO_BASE, 32'hFFFF_0000, target-1 window base
- MMIO_MASK, 32'hFFFF_0000, decode mask; target 1 when (addr & MMIO_MASK) == MMIO_BASE
- TIMEOUT, 255, max cycles spent in ISSUE+WAIT before an error response; ≥ 2
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  demux can accept a request
- req_addr  in  ADDR_W  byte address
- req_we  in  1  1 = write, 0 = read
- req_wdata  in  DATA_W  write data
- req_be  in  DATA_W/8  byte enables
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  DATA_W  read data; 0 for writes and errors
- resp_err  out  1  timeout error, qualified by resp_valid
- out_addr  out  ADDR_W  latched address, broadcast to both targets
- out_we  out  1  latched write flag
- out_wdata  out  DATA_W  latched write data
- out_be  out  DATA_W/8  latched byte enables
- t0_valid / t1_valid  out  1  request valid to target 0 / 1
- t0_ready / t1_ready  in  1  target accepts request
- t0_rvalid / t1_rvalid  in  1  target read data valid
- t0_rdata / t1_rdata  in  DATA_W  target read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- req_ready = (state == IDLE). It is combinational and therefore 1 while in reset.
- IDLE: on req_valid & req_ready, latch addr/we/wdata/be into out_*, latch sel = decode(req_addr), clear the timeout counter, and go to ISSUE.
- ISSUE: assert t{sel}_valid only; the other target's valid stays 0. Hold out_* stable until t{sel}_ready.
  - Handshake on a write: go to RESP with err=0 and rdata=0.
  - Handshake on a read with t{sel}_rvalid in the same cycle: capture t{sel}_rdata and go to RESP.
  - Handshake on a read without rvalid: go to WAIT.
- WAIT: on t{sel}_rvalid, capture t{sel}_rdata and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
- rvalid from the unselected target, or rvalid in IDLE or RESP, is ignored.
- Timeout: the counter increments every cycle in ISSUE and WAIT. In the cycle the counter equals TIMEOUT-1 with no completion, go to RESP with resp_err=1 and resp_rdata=0, and drop t{sel}_valid. If completion and timeout fall in the same cycle, completion wins.
- Reset (any time, including mid-transaction):
  - state IDLE
  - resp_valid, resp_err, resp_rdata, t0_valid, t1_valid, out_addr, out_we, out_wdata, out_be, and the counter all go to 0
  - any in-flight transaction is dropped with no response.

## Timing
- Request accepted in cycle N. t{sel}_valid is high from N+1.
- Write with t_ready at N+1: resp_valid at N+2, req_ready high again at N+3.
- Read with ready and rvalid both at N+1: resp_valid at N+2. Read with rvalid at N+k (k ≥ 2): resp_valid at N+k+1.
- Minimum back-to-back spacing is 3 cycles between accepts.
- Timeout response: resp_valid at cycle N+1+TIMEOUT.
- resp_rdata and resp_err are valid only while resp_valid=1. Outside RESP both are driven 0.

## Test plan
- Reset: rst_n=0 for 3 cycles → resp_valid=0, t0_valid=t1_valid=0, out_addr=0, req_ready=1. Release rst_n → same values.
- DMEM read: addr 0x0000_1000; t0 gives ready at N+1 and rvalid with rdata 0xDEADBEEF at N+3 → resp_valid at N+4 with rdata 0xDEADBEEF, err=0. t1_valid stays 0 throughout.
- MMIO write: addr 0xFFFF_0004, wdata 0x55, be 4'b0001; t1_ready held 0 for 4 cycles → t1_valid held with out_* stable. resp_valid arrives 1 cycle after the handshake, with rdata=0 and err=0.
- Timeout: TIMEOUT=8, read to 0x2000, t0 never responds → resp_valid=1, resp_err=1, rdata=0 at N+9, then req_ready=1.
- Stray/simultaneous: during a pending t0 read, t1_rvalid pulses with rdata 0x1234 → ignored. Then t0_rvalid arrives in the timeout cycle → normal response, err=0.
- Mid-transaction reset: assert rst_n=0 while in WAIT → outputs clear asynchronously, and no resp_valid follows. Next request completes normally.

Source files
------------

// File: rtl/dbus_demux_if.sv
// Bus bundle for dbus_demux: core request/response, broadcast request fields,
// and the per-target handshake. "master" is the core + targets side, "slave" is the demux.
interface dbus_demux_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    // Core request/response
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_we;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    // Latched request, shared by both targets
    logic [ADDR_W-1:0] out_addr;
    logic              out_we;
    logic [DATA_W-1:0] out_wdata;
    logic [BE_W-1:0]   out_be;

    // Target handshakes
    logic              t0_valid;
    logic              t0_ready;
    logic              t0_rvalid;
    logic [DATA_W-1:0] t0_rdata;
    logic              t1_valid;
    logic              t1_ready;
    logic              t1_rvalid;
    logic [DATA_W-1:0] t1_rdata;

    modport master (
        output req_valid, req_addr, req_we, req_wdata, req_be,
        output t0_ready, t0_rvalid, t0_rdata,
        output t1_ready, t1_rvalid, t1_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  out_addr, out_we, out_wdata, out_be,
        input  t0_valid, t1_valid
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, req_be,
        input  t0_ready, t0_rvalid, t0_rdata,
        input  t1_ready, t1_rvalid, t1_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output out_addr, out_we, out_wdata, out_be,
        output t0_valid, t1_valid
    );
endinterface

// File: rtl/dbus_demux.sv
// Load/store bus router: steers one outstanding core request to DMEM (target 0) or
// the MMIO window (target 1) and returns its response, or an error on timeout.
module dbus_demux #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] MMIO_BASE = 32'hFFFF_0000,
    parameter logic [ADDR_W-1:0] MMIO_MASK = 32'hFFFF_0000,
    parameter int unsigned       TIMEOUT   = 255
) (
    input logic         clk,
    input logic         rst_n,
    dbus_demux_if.slave bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_we_q, out_we_d;
    logic [DATA_W-1:0] out_wdata_q, out_wdata_d;
    logic [BE_W-1:0]   out_be_q, out_be_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              tgt_ready;
    logic              tgt_rvalid;
    logic [DATA_W-1:0] tgt_rdata;
    logic              timeout_hit;

    // Only the selected target's handshake is ever looked at; the other one is ignored.
    assign tgt_ready   = sel_q ? bus.t1_ready  : bus.t0_ready;
    assign tgt_rvalid  = sel_q ? bus.t1_rvalid : bus.t0_rvalid;
    assign tgt_rdata   = sel_q ? bus.t1_rdata  : bus.t0_rdata;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        out_addr_d  = out_addr_q;
        out_we_d    = out_we_q;
        out_wdata_d = out_wdata_q;
        out_be_d    = out_be_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        err_d       = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    out_addr_d  = bus.req_addr;
                    out_we_d    = bus.req_we;
                    out_wdata_d = bus.req_wdata;
                    out_be_d    = bus.req_be;
                    sel_d       = ((bus.req_addr & MMIO_MASK) == MMIO_BASE);
                    cnt_d       = '0;
                    rdata_d     = '0;
                    err_d       = 1'b0;
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Completion is checked before the timeout so it wins a same-cycle tie.
                if (tgt_ready && (out_we_q || tgt_rvalid)) begin
                    rdata_d = out_we_q ? '0 : tgt_rdata;
                    state_d = StResp;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (tgt_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (tgt_rvalid) begin
                    rdata_d = tgt_rdata;
                    state_d = StResp;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sel_q       <= 1'b0;
            out_addr_q  <= '0;
            out_we_q    <= 1'b0;
            out_wdata_q <= '0;
            out_be_q    <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_addr_q  <= out_addr_d;
            out_we_q    <= out_we_d;
            out_wdata_q <= out_wdata_d;
            out_be_q    <= out_be_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.t0_valid   = (state_q == StIssue) && !sel_q;
    assign bus.t1_valid   = (state_q == StIssue) && sel_q;
    assign bus.out_addr   = out_addr_q;
    assign bus.out_we     = out_we_q;
    assign bus.out_wdata  = out_wdata_q;
    assign bus.out_be     = out_be_q;
    // Response fields are forced to zero outside the response cycle.
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_err   = (state_q == StResp) && err_q;
    assign bus.resp_rdata = (state_q == StResp) ? rdata_q : '0;

    a_one_target: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.t0_valid && bus.t1_valid));

    a_resp_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        bus.resp_valid |=> !bus.resp_valid);

    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == StIssue) |=> $stable({out_addr_q, out_we_q, out_wdata_q, out_be_q}));
endmodule

// File: tb/tb_dbus_demux.sv
// Scenario bench for dbus_demux: expected responses are queued at request time
// and popped when the demux answers; TIMEOUT is shortened to 8.
module tb_dbus_demux;
    localparam int unsigned TMO = 8;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t sb[$];

    dbus_demux_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dbus_demux #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MMIO_BASE(32'hFFFF_0000),
        .MMIO_MASK(32'hFFFF_0000),
        .TIMEOUT  (TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue_req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                             input logic [3:0] be, output int n);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_we    = we;
        bus.req_wdata = wd;
        bus.req_be    = be;
        n = cyc;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_we = 1'b0;
        bus.req_wdata = '0;   bus.req_be = '0;
        bus.t0_ready = 1'b0;  bus.t0_rvalid = 1'b0; bus.t0_rdata = '0;
        bus.t1_ready = 1'b0;  bus.t1_rvalid = 1'b0; bus.t1_rdata = '0;
        rst_n = 1'b0;
        cyc = 0;
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if ({bus.req_ready, bus.resp_valid, bus.t0_valid, bus.t1_valid, bus.out_addr} !==
            {4'b1000, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_held: got rdy/rv/v0/v1/addr=%b%b%b%b/%h want 1000/00000000",
                     bus.req_ready, bus.resp_valid, bus.t0_valid, bus.t1_valid, bus.out_addr);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({bus.req_ready, bus.resp_valid, bus.t0_valid, bus.t1_valid, bus.out_addr} !==
            {4'b1000, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_release: got rdy/rv/v0/v1/addr=%b%b%b%b/%h want 1000/00000000",
                     bus.req_ready, bus.resp_valid, bus.t0_valid, bus.t1_valid, bus.out_addr);
        end
    endtask

    task automatic test_dmem_read();
        int   n;
        logic t1_seen;
        exp_t e;
        t1_seen = 1'b0;
        sb.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF, cyc: cyc + 4});
        issue_req(32'h0000_1000, 1'b0, 32'h0, 4'hF, n);
        t1_seen |= bus.t1_valid;
        n_tests++;
        if (bus.t0_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL dmem_t0_valid: got %b want 1", bus.t0_valid);
        end
        bus.t0_ready = 1'b1;
        tick();
        bus.t0_ready = 1'b0;
        t1_seen |= bus.t1_valid;
        tick();
        t1_seen |= bus.t1_valid;
        n_tests++;
        if (bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dmem_early_resp: got %b want 0 at N+3", bus.resp_valid);
        end
        bus.t0_rvalid = 1'b1;
        bus.t0_rdata  = 32'hDEAD_BEEF;
        tick();
        bus.t0_rvalid = 1'b0;
        bus.t0_rdata  = '0;
        t1_seen |= bus.t1_valid;
        e = sb.size() ? sb.pop_front() : '0;
        n_tests++;
        if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {1'b1, e.err, e.rdata}
            || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL dmem_resp: got v/err/rdata=%b/%b/%h @%0d want 1/%b/%h @%0d",
                     bus.resp_valid, bus.resp_err, bus.resp_rdata, cyc, e.err, e.rdata, e.cyc);
        end
        tick();
        n_tests++;
        if ({bus.req_ready, bus.resp_valid, t1_seen} !== 3'b100) begin
            n_fail++;
            $display("FAIL dmem_after: got rdy/rv/t1_seen=%b%b%b want 100",
                     bus.req_ready, bus.resp_valid, t1_seen);
        end
    endtask

    task automatic test_mmio_write();
        int   n;
        exp_t e;
        logic [70:0] want;
        want = {1'b1, 1'b0, 1'b1, 4'b0001, 32'hFFFF_0004, 32'h0000_0055};
        sb.push_back('{err: 1'b0, rdata: 32'h0, cyc: cyc + 6});
        issue_req(32'hFFFF_0004, 1'b1, 32'h0000_0055, 4'b0001, n);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({bus.t1_valid, bus.t0_valid, bus.out_we, bus.out_be, bus.out_addr,
                 bus.out_wdata} !== want) begin
                n_fail++;
                $display("FAIL mmio_hold%0d: got v1/v0/we/be/addr/wd=%b/%b/%b/%b/%h/%h want %h",
                         i, bus.t1_valid, bus.t0_valid, bus.out_we, bus.out_be, bus.out_addr,
                         bus.out_wdata, want);
            end
            tick();
        end
        // Stale read data on a write handshake must not leak into the response.
        bus.t1_ready  = 1'b1;
        bus.t1_rvalid = 1'b1;
        bus.t1_rdata  = 32'hCAFE_F00D;
        tick();
        bus.t1_ready  = 1'b0;
        bus.t1_rvalid = 1'b0;
        bus.t1_rdata  = '0;
        e = sb.size() ? sb.pop_front() : '0;
        n_tests++;
        if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {1'b1, e.err, e.rdata}
            || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL mmio_resp: got v/err/rdata=%b/%b/%h @%0d want 1/%b/%h @%0d",
                     bus.resp_valid, bus.resp_err, bus.resp_rdata, cyc, e.err, e.rdata, e.cyc);
        end
        tick();
    endtask

    task automatic test_timeout();
        int   n;
        exp_t e;
        sb.push_back('{err: 1'b1, rdata: 32'h0, cyc: cyc + 1 + TMO});
        issue_req(32'h0000_2000, 1'b0, 32'h0, 4'hF, n);
        for (int i = 0; i < TMO - 1; i++) tick();
        n_tests++;
        if ({bus.t0_valid, bus.resp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL tmo_before: got v0/rv=%b%b want 10 at N+%0d",
                     bus.t0_valid, bus.resp_valid, cyc - n);
        end
        tick();
        e = sb.size() ? sb.pop_front() : '0;
        n_tests++;
        if ({bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.t0_valid} !==
            {1'b1, e.err, e.rdata, 1'b0} || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL tmo_resp: got v/err/rdata/v0=%b/%b/%h/%b @%0d want 1/%b/%h/0 @%0d",
                     bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.t0_valid, cyc,
                     e.err, e.rdata, e.cyc);
        end
        tick();
        n_tests++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err} !== 3'b100) begin
            n_fail++;
            $display("FAIL tmo_after: got rdy/rv/err=%b%b%b want 100",
                     bus.req_ready, bus.resp_valid, bus.resp_err);
        end
    endtask

    task automatic test_stray();
        int   n;
        exp_t e;
        sb.push_back('{err: 1'b0, rdata: 32'hA5A5_0001, cyc: cyc + 1 + TMO});
        issue_req(32'h0000_1000, 1'b0, 32'h0, 4'hF, n);
        bus.t0_ready = 1'b1;
        tick();
        bus.t0_ready = 1'b0;
        tick();
        bus.t1_rvalid = 1'b1;
        bus.t1_rdata  = 32'h0000_1234;
        tick();
        bus.t1_rvalid = 1'b0;
        bus.t1_rdata  = '0;
        n_tests++;
        if (bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_t1_rvalid: got resp_valid=%b want 0", bus.resp_valid);
        end
        while (cyc < n + TMO) tick();
        // Target answers in the very cycle the timeout would fire.
        bus.t0_rvalid = 1'b1;
        bus.t0_rdata  = 32'hA5A5_0001;
        tick();
        bus.t0_rvalid = 1'b0;
        bus.t0_rdata  = '0;
        e = sb.size() ? sb.pop_front() : '0;
        n_tests++;
        if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {1'b1, e.err, e.rdata}
            || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL stray_tie_resp: got v/err/rdata=%b/%b/%h @%0d want 1/%b/%h @%0d",
                     bus.resp_valid, bus.resp_err, bus.resp_rdata, cyc, e.err, e.rdata, e.cyc);
        end
        tick();
        bus.t0_rvalid = 1'b1;
        bus.t0_rdata  = 32'h7777_7777;
        tick();
        bus.t0_rvalid = 1'b0;
        bus.t0_rdata  = '0;
        n_tests++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_rdata} !== {2'b10, 32'h0}) begin
            n_fail++;
            $display("FAIL stray_idle_rvalid: got rdy/rv/rdata=%b%b/%h want 10/00000000",
                     bus.req_ready, bus.resp_valid, bus.resp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        logic [31:0] mix;
        int          k;
        int          got;
        int          last_acc;
        exp_t        e;
        addrs[0] = 32'h0000_0100; addrs[1] = 32'h0000_0204;
        addrs[2] = 32'h0000_0308; addrs[3] = 32'h0000_040C;
        mix      = 32'h5A5A_0F0F;
        k = 0; got = 0; last_acc = 0;
        bus.t0_ready  = 1'b1;
        bus.t0_rvalid = 1'b1;
        for (int c = 0; c < 60 && got < 4; c++) begin
            if (bus.resp_valid === 1'b1) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_resp: got unexpected response @%0d want none", cyc);
                end else begin
                    e = sb.pop_front();
                    if ({bus.resp_err, bus.resp_rdata} !== {e.err, e.rdata} || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL b2b_resp: got err/rdata=%b/%h @%0d want %b/%h @%0d",
                                 bus.resp_err, bus.resp_rdata, cyc, e.err, e.rdata, e.cyc);
                    end
                end
                got++;
            end
            if (k < 4) begin
                bus.req_valid = 1'b1;
                bus.req_addr  = addrs[k];
                bus.req_we    = 1'b0;
            end else begin
                bus.req_valid = 1'b0;
            end
            if (bus.req_valid && bus.req_ready) begin
                if (k > 0) begin
                    n_tests++;
                    if (cyc - last_acc != 3) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: got %0d cycles want 3", cyc - last_acc);
                    end
                end
                sb.push_back('{err: 1'b0, rdata: addrs[k] ^ mix, cyc: cyc + 2});
                bus.t0_rdata = addrs[k] ^ mix;
                last_acc = cyc;
                k++;
            end
            tick();
        end
        bus.req_valid = 1'b0;
        bus.t0_ready  = 1'b0;
        bus.t0_rvalid = 1'b0;
        bus.t0_rdata  = '0;
        n_tests++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d responses want 4", got);
        end
    endtask

    task automatic test_mid_reset();
        int   n;
        logic rv_seen;
        exp_t e;
        issue_req(32'h0000_1000, 1'b0, 32'h0, 4'hF, n);
        bus.t0_ready = 1'b1;
        tick();
        bus.t0_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.req_ready, bus.t0_valid, bus.t1_valid, bus.resp_valid, bus.resp_err,
             bus.resp_rdata, bus.out_addr, bus.out_we, bus.out_wdata, bus.out_be} !==
            {5'b10000, 32'h0, 32'h0, 1'b0, 32'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL midrst_async: got rdy/v0/v1/rv=%b%b%b%b addr=%h we=%b wd=%h be=%b",
                     bus.req_ready, bus.t0_valid, bus.t1_valid, bus.resp_valid, bus.out_addr,
                     bus.out_we, bus.out_wdata, bus.out_be);
        end
        // A late answer for the dropped request must not produce a response.
        bus.t0_rvalid = 1'b1;
        bus.t0_rdata  = 32'h1111_2222;
        tick();
        tick();
        rst_n = 1'b1;
        rv_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            rv_seen |= bus.resp_valid;
            bus.t0_rvalid = 1'b0;
        end
        n_tests++;
        if (rv_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_resp: got resp_valid seen=%b want 0", rv_seen);
        end
        bus.t0_ready  = 1'b1;
        bus.t0_rvalid = 1'b1;
        bus.t0_rdata  = 32'h0BAD_F00D;
        sb.push_back('{err: 1'b0, rdata: 32'h0BAD_F00D, cyc: cyc + 2});
        issue_req(32'h0000_1000, 1'b0, 32'h0, 4'hF, n);
        tick();
        bus.t0_ready  = 1'b0;
        bus.t0_rvalid = 1'b0;
        bus.t0_rdata  = '0;
        e = sb.size() ? sb.pop_front() : '0;
        n_tests++;
        if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== {1'b1, e.err, e.rdata}
            || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL midrst_next: got v/err/rdata=%b/%b/%h @%0d want 1/%b/%h @%0d",
                     bus.resp_valid, bus.resp_err, bus.resp_rdata, cyc, e.err, e.rdata, e.cyc);
        end
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_dmem_read();
        test_mmio_write();
        test_timeout();
        test_stray();
        test_back_to_back();
        test_mid_reset();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
